// File: rtl/btn_debounce.sv
// btn_debounce: turns raw, bouncy, asynchronous buttons/switches into clean,
// synchronized levels plus single-cycle rise/fall pulses.
// Pipeline: 2-flop synchronizer -> shared sample-tick prescaler ->
// per-channel stability counter.
// Optional feature macro: BTN_LONG_PRESS_EN adds the long_press output and a
// per-channel hold counter that fires once per press after LONG_TICKS ticks.
module btn_debounce #(
    parameter int WIDTH        = 8,
    parameter int CLK_DIV      = 100000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
`ifdef BTN_LONG_PRESS_EN
    output logic [WIDTH-1:0] long_press,
`endif
    output logic             sample_tick
);

    // A 1-bit prescaler is still needed when CLK_DIV is 1 (it simply stays 0).
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Elaboration-time guard against illegal configurations.
    if (CLK_DIV < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
        $error("btn_debounce: CLK_DIV, STABLE_TICKS and LONG_TICKS must all be >= 1");
    end

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt [WIDTH];

    // ---- stage p0/p1: two-flop synchronizer, only sync_p1 is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // ---- shared prescaler: registered one-cycle strobe every CLK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            sample_tick <= (div_cnt == DIV_LAST);
        end
    end

    // ---- per-channel stability counter: flip on the STABLE_TICKS-th
    // ---- consecutive mismatching tick, pulse rise/fall on that same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            btn_level <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
        end else begin
            btn_rise <= '0;
            btn_fall <= '0;
            if (sample_tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync_p1[i] == btn_level[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        cnt[i]       <= '0;
                        btn_level[i] <= ~btn_level[i];
                        btn_rise[i]  <= ~btn_level[i];
                        btn_fall[i]  <= btn_level[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_TICKS - 1);

    logic [HOLD_W-1:0] hold [WIDTH];

    // ---- hold counter: counts ticks while pressed, saturates so each press
    // ---- yields a single long_press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                hold[i] <= '0;
            end
            long_press <= '0;
        end else begin
            long_press <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (!btn_level[i] || btn_rise[i]) begin
                    hold[i] <= '0;
                end else if (sample_tick && hold[i] != HOLD_LAST) begin
                    hold[i] <= hold[i] + 1'b1;
                    if (hold[i] == HOLD_PRE) begin
                        long_press[i] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce (CLK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5).
// Expected edge events are queued when stimulus is applied and retired by a
// negedge monitor whenever the DUT emits a rise/fall (or long_press) pulse.
`timescale 1ns/1ps
module tb_btn_debounce;

    localparam int WIDTH        = 8;
    localparam int CLK_DIV      = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 5;
    localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * CLK_DIV + 1;
    localparam int LAT_MAX      = 2 + STABLE_TICKS * CLK_DIV;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] btn_in;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_rise;
    logic [WIDTH-1:0] btn_fall;
    logic             sample_tick;
`ifdef BTN_LONG_PRESS_EN
    logic [WIDTH-1:0] long_press;
`endif

    btn_debounce #(
        .WIDTH        (WIDTH),
        .CLK_DIV      (CLK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
`ifdef BTN_LONG_PRESS_EN
        .long_press  (long_press),
`endif
        .sample_tick (sample_tick)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        int               c0;
    } ev_t;

    ev_t              exp_q[$];
    logic [WIDTH-1:0] long_q[$];

    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    int               last_tick = 0;
    int               last_rise [WIDTH];
    logic [WIDTH-1:0] prev_level = '0;
    bit               mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Apply a new input pattern right after a rising edge; optionally queue the edge pulse it should cause.
    task automatic drive(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall);
        ev_t e;
        @(posedge clk);
        #1;
        btn_in = v;
        if ((rise | fall) != '0) begin
            e.rise = rise;
            e.fall = fall;
            e.c0   = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || long_q.size() != 0); i++) begin
            @(posedge clk);
        end
        check("drain_events", exp_q.size(), 0);
        check("drain_long", long_q.size(), 0);
    endtask

    // Negedge monitor: tick period, level/pulse consistency, scoreboard retirement.
    always @(negedge clk) begin
        ev_t              e;
        int               lat;
        logic [WIDTH-1:0] m;
        if (mon_en && rst_n) begin
            if (sample_tick) begin
                check("tick_period", cyc - last_tick, CLK_DIV);
                last_tick = cyc;
            end
            check("level_vs_pulse", btn_level ^ prev_level, btn_rise | btn_fall);
            check("rise_fall_overlap", btn_rise & btn_fall, 0);
            if ((btn_rise | btn_fall) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {btn_rise, btn_fall}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_mask", btn_rise, e.rise);
                    check("fall_mask", btn_fall, e.fall);
                    lat = cyc - e.c0;
                    check("latency_ge_min", (lat >= LAT_MIN) ? LAT_MIN : lat, LAT_MIN);
                    check("latency_le_max", (lat <= LAT_MAX) ? LAT_MAX : lat, LAT_MAX);
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (btn_rise[i]) last_rise[i] = cyc;
                end
            end
`ifdef BTN_LONG_PRESS_EN
            if (long_press != '0) begin
                if (long_q.size() == 0) begin
                    check("unexpected_long", long_press, 0);
                end else begin
                    m = long_q.pop_front();
                    check("long_mask", long_press, m);
                    lat = -1;
                    for (int i = WIDTH - 1; i >= 0; i--) begin
                        if (long_press[i]) lat = cyc - last_rise[i];
                    end
                    check("long_delay", lat, LONG_TICKS * CLK_DIV);
                end
            end
`else
            m = '0;
`endif
        end
        prev_level = btn_level;
    end

    initial begin
        for (int i = 0; i < WIDTH; i++) last_rise[i] = 0;
        rst_n  = 1'b0;
        btn_in = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_level", btn_level, 0);
        check("rst_rise", btn_rise, 0);
        check("rst_fall", btn_fall, 0);
        check("rst_tick", sample_tick, 0);
`ifdef BTN_LONG_PRESS_EN
        check("rst_long", long_press, 0);
`endif

        // Release with all inputs high: levels rise only after 3 ticks.
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_tick = cyc;
        exp_q.push_back('{rise: 8'hFF, fall: 8'h00, c0: cyc});
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_level_low", btn_level, 0);
        wait_drain(40);
        drive(8'h00, 8'h00, 8'hFF);
        wait_drain(40);

        // Clean press and release on bit 0.
        drive(8'h01, 8'h01, 8'h00);
        wait_drain(40);
        check("press_level", btn_level, 8'h01);
        drive(8'h00, 8'h00, 8'h01);
        wait_drain(40);

        // Glitch on bit 3 shorter than the stability window.
        drive(8'h08, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        drive(8'h00, 8'h00, 8'h00);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_level", btn_level, 0);

        // Multi-bit press and release.
        drive(8'h81, 8'h81, 8'h00);
`ifdef BTN_LONG_PRESS_EN
        long_q.push_back(8'h81);
`endif
        repeat (39) @(posedge clk);
        drive(8'h00, 8'h00, 8'h81);
        wait_drain(40);

        // Async reset in the middle of a debounce, with bit 6 already high.
        drive(8'h40, 8'h40, 8'h00);
        wait_drain(40);
        drive(8'h60, 8'h00, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_level", btn_level, 0);
        check("midrst_rise", btn_rise, 0);
        check("midrst_fall", btn_fall, 0);
        check("midrst_tick", sample_tick, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_tick = cyc;
        exp_q.push_back('{rise: 8'h60, fall: 8'h00, c0: cyc});
        wait_drain(40);
        drive(8'h00, 8'h00, 8'h60);
        wait_drain(40);

        // Long hold on bit 2.
        drive(8'h04, 8'h04, 8'h00);
`ifdef BTN_LONG_PRESS_EN
        long_q.push_back(8'h04);
`endif
        repeat (59) @(posedge clk);
        drive(8'h00, 8'h00, 8'h04);
        wait_drain(40);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("final_level", btn_level, 0);
        check("final_queue", exp_q.size(), 0);
        check("final_long_queue", long_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
